// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder that sits directly below the bus arbiter. Each
//   single-word read or write request is latched in IDLE, held for
//   WAIT_STATES extra cycles, then serviced from an internal word RAM.
//   Completion is signalled by a one-cycle memory_ready pulse, and read data
//   is returned in a register that holds until the next read completes.
//
// Parameters
//   DEPTH        number of 32-bit words in the RAM
//   WAIT_STATES  extra cycles before each access completes (0..15)
//
// Ports
//   clk                system clock, all state updates on its rising edge
//   reset              synchronous, active-low reset (RAM contents are kept)
//   memory_read        read request
//   memory_write       write request (wins when both requests are high)
//   memory_address     byte address, word index = bits [log2(DEPTH)+1:2]
//   memory_write_data  write data
//   memory_read_data   registered read data
//   memory_ready       one-cycle completion pulse
//   memory_busy        high while a transaction is in flight
//   memory_error       only with MEM_RESPONDER_OOR_ERR_EN: pulses with
//                      memory_ready when the byte address is >= DEPTH*4
//
// Optional feature macro: MEM_RESPONDER_OOR_ERR_EN
//   Defined:   out-of-range requests suppress writes, reads return
//              32'hDEADBEEF, and memory_error flags the completion.
//   Undefined: memory_error is absent and addresses wrap modulo DEPTH.

module mem_responder #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  output logic [31:0] memory_read_data,
  output logic        memory_ready,
  output logic        memory_busy
`ifdef MEM_RESPONDER_OOR_ERR_EN
  ,
  output logic        memory_error
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] OOR_READ_VALUE = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic            op_write_q, op_write_d;
  logic [AW-1:0]   index_q, index_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic [31:0]     ram [DEPTH];

  logic            request;
  logic            do_access;
  logic            acc_write;
  logic [AW-1:0]   acc_index;
  logic [31:0]     acc_wdata;
  logic            acc_oor;
  logic            ram_we;

  assign request = memory_read | memory_write;

`ifdef MEM_RESPONDER_OOR_ERR_EN
  logic in_oor;
  logic oor_q, oor_d;
  logic err_q, err_d;
  logic unused_addr_bits;

  // Any set bit above the word index puts the byte address past the RAM.
  assign in_oor           = (memory_address[31:AW+2] != '0);
  assign unused_addr_bits = ^memory_address[1:0];
`else
  logic unused_addr_bits;

  // Byte-lane bits and the bits above the index are deliberately dropped.
  assign unused_addr_bits = ^{memory_address[31:AW+2], memory_address[1:0]};
`endif

  // Next-state logic. With zero wait states the access happens on the same
  // edge that samples the request, so the access operands come straight from
  // the inputs in that case and from the latched copies otherwise.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_write_d = op_write_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    do_access  = 1'b0;
    acc_write  = op_write_q;
    acc_index  = index_q;
    acc_wdata  = wdata_q;
`ifdef MEM_RESPONDER_OOR_ERR_EN
    oor_d      = oor_q;
    acc_oor    = oor_q;
`else
    acc_oor    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (request) begin
          op_write_d = memory_write;
          index_d    = memory_address[AW+1:2];
          wdata_d    = memory_write_data;
          busy_d     = 1'b1;
`ifdef MEM_RESPONDER_OOR_ERR_EN
          oor_d      = in_oor;
`endif
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            acc_write = memory_write;
            acc_index = memory_address[AW+1:2];
            acc_wdata = memory_write_data;
`ifdef MEM_RESPONDER_OOR_ERR_EN
            acc_oor   = in_oor;
`endif
            state_d   = S_DONE;
          end else begin
            count_d = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (count_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = S_DONE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    ready_d = do_access;
    rdata_d = rdata_q;
    if (do_access && !acc_write) begin
      rdata_d = acc_oor ? OOR_READ_VALUE : ram[acc_index];
    end
`ifdef MEM_RESPONDER_OOR_ERR_EN
    err_d = do_access & acc_oor;
`endif
  end

  // A write is gated by reset so an access pending when reset arrives never
  // reaches the RAM; out-of-range writes are dropped as well.
  assign ram_we = do_access & acc_write & ~acc_oor & reset;

  // RAM array has no reset so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[acc_index] <= acc_wdata;
    end
  end

  // Control and output registers. The latched request operands are not
  // reset because they are always reloaded before being used.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_RESPONDER_OOR_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef MEM_RESPONDER_OOR_ERR_EN
      err_q   <= err_d;
`endif
    end
    op_write_q <= op_write_d;
    index_q    <= index_d;
    wdata_q    <= wdata_d;
`ifdef MEM_RESPONDER_OOR_ERR_EN
    oor_q      <= oor_d;
`endif
  end

  assign memory_read_data = rdata_q;
  assign memory_ready     = ready_q;
  assign memory_busy      = busy_q;
`ifdef MEM_RESPONDER_OOR_ERR_EN
  assign memory_error     = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder. Two instances share clock and reset:
//   dut uses one wait state, dut0 uses zero wait states. Every step drives
//   inputs and samples outputs 1 time unit after the rising edge.
//   Optional feature macro: MEM_RESPONDER_OOR_ERR_EN (also switches the
//   expected values of the out-of-range steps).

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        rd1, wr1, ready1, busy1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        rd0, wr0, ready0, busy0;
  logic [31:0] addr0, wdata0, rdata0;
`ifdef MEM_RESPONDER_OOR_ERR_EN
  logic        err1, err0;
`endif

  int          errors = 0;
  int          checks = 0;
  logic        last_err;
  logic [9:0]  ready_mask;
  int          pulses;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  mem_responder #(.DEPTH(4096), .WAIT_STATES(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .memory_read       (rd1),
    .memory_write      (wr1),
    .memory_address    (addr1),
    .memory_write_data (wdata1),
    .memory_read_data  (rdata1),
    .memory_ready      (ready1),
    .memory_busy       (busy1)
`ifdef MEM_RESPONDER_OOR_ERR_EN
    ,
    .memory_error      (err1)
`endif
  );

  mem_responder #(.DEPTH(4096), .WAIT_STATES(0)) dut0 (
    .clk               (clk),
    .reset             (reset),
    .memory_read       (rd0),
    .memory_write      (wr0),
    .memory_address    (addr0),
    .memory_write_data (wdata0),
    .memory_read_data  (rdata0),
    .memory_ready      (ready0),
    .memory_busy       (busy0)
`ifdef MEM_RESPONDER_OOR_ERR_EN
    ,
    .memory_error      (err0)
`endif
  );

  // Advance one clock and step just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to dut (sel=1) or dut0 (sel=0), hold it until ready,
  // then check latency, busy length and that the handshake closes.
  task automatic applyStimulus(input bit sel, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int exp_lat, input string tag);
    int lat      = 0;
    int busy_cnt = 0;
    bit seen     = 1'b0;
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = data;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = data;
    end
    last_err = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      if (sel ? busy1 : busy0) busy_cnt++;
      if (sel ? ready1 : ready0) begin
        seen = 1'b1;
`ifdef MEM_RESPONDER_OOR_ERR_EN
        last_err = sel ? err1 : err0;
`endif
      end
    end
    rd1 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    tick();
    checkOutput({tag, "_ready_after"}, {31'd0, (sel ? ready1 : ready0)}, 32'd0);
    checkOutput({tag, "_busy_after"}, {31'd0, (sel ? busy1 : busy0)}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    last_err = 1'b0;

    // Reset held for three cycles, then released.
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_rdata1", rdata1, 32'd0);
    checkOutput("rst_ready1", {31'd0, ready1}, 32'd0);
    checkOutput("rst_busy1", {31'd0, busy1}, 32'd0);
    checkOutput("rst_rdata0", rdata0, 32'd0);
    checkOutput("rst_ready0", {31'd0, ready0}, 32'd0);
    checkOutput("rst_busy0", {31'd0, busy0}, 32'd0);

    // No ready pulses while idle.
    pulses = 0;
    repeat (4) begin
      tick();
      if (ready1 || ready0) pulses++;
    end
    checkOutput("idle_pulses", 32'(pulses), 32'd0);

    // One wait state: write then read back.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h104, 32'h12345678, 2, "wr104");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 2, "rd104");
    checkOutput("rd104_data", rdata1, 32'h12345678);

    // Zero wait states: ready the cycle after the sampling edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 1, "z_wr0");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1, "z_rd0");
    checkOutput("z_rd0_data", rdata0, 32'hA5A5A5A5);

    // Held read of 0x8: ready on loop ticks 2, 5 and 8.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'h11112222, 2, "wr8");
    rd1 = 1'b1; addr1 = 32'h8;
    ready_mask = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ready_mask[i] = ready1;
    end
    rd1 = 1'b0;
    repeat (3) tick();
    checkOutput("held_ready_mask", {22'd0, ready_mask}, 32'h092);
    checkOutput("held_data", rdata1, 32'h11112222);
    checkOutput("held_busy_end", {31'd0, busy1}, 32'd0);

    // Priority and wrap/out-of-range at byte address 0x4000.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'h5555AAAA, 2, "wr0");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h4000, 32'hCAFEF00D, 2, "prio");
    checkOutput("prio_data_kept", rdata1, 32'h11112222);
`ifdef MEM_RESPONDER_OOR_ERR_EN
    checkOutput("prio_err", {31'd0, last_err}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2, "rd_wrap0");
    checkOutput("rd_wrap0_data", rdata1, 32'h5555AAAA);
    checkOutput("rd_wrap0_err", {31'd0, last_err}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 2, "rd_oor");
    checkOutput("rd_oor_data", rdata1, 32'hDEADBEEF);
    checkOutput("rd_oor_err", {31'd0, last_err}, 32'd1);
`else
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2, "rd_wrap0");
    checkOutput("rd_wrap0_data", rdata1, 32'hCAFEF00D);
`endif

    // Reset while a write sits in WAIT: no ready, RAM untouched.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h3C3C3C3C, 2, "wr20");
    wr1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hFFFFFFFF;
    tick();
    checkOutput("midrst_busy_wait", {31'd0, busy1}, 32'd1);
    reset = 1'b0;
    wr1 = 1'b0;
    tick();
    checkOutput("midrst_ready", {31'd0, ready1}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy1}, 32'd0);
    checkOutput("midrst_rdata", rdata1, 32'd0);
    reset = 1'b1;
    pulses = 0;
    repeat (3) begin
      tick();
      if (ready1) pulses++;
    end
    checkOutput("midrst_no_pulse", 32'(pulses), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 2, "rd20");
    checkOutput("rd20_data", rdata1, 32'h3C3C3C3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
